// File: rtl/multi_tick_gen_if.sv
// Configuration, enable and tick/clock bundle for the multi-channel tick generator.
// The master side drives enables, resync and divisor writes; the slave side is the divider.
interface multi_tick_gen_if #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 26,
    parameter int CH_W  = 2
);
    logic [N_CH-1:0]  en;
    logic             sync;
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ack;
    logic             cfg_err;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  clock_out;

    modport master (
        output en, sync, cfg_wr, cfg_ch, cfg_div,
        input  cfg_ack, cfg_err, tick, clock_out
    );

    modport slave (
        input  en, sync, cfg_wr, cfg_ch, cfg_div,
        output cfg_ack, cfg_err, tick, clock_out
    );
endinterface

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable divider: each channel emits a one-cycle tick every d
// enabled cycles and a square wave toggling on every tick. Divisors are written at
// runtime through a single config port; a sync pulse realigns every channel's phase.
module multi_tick_gen #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 26,
    parameter int CH_W        = 2,
    parameter int DEFAULT_DIV = 25000000
) (
    input  logic           clock_50,
    input  logic           reset,
    multi_tick_gen_if.slave bus
);

    // One extra bit so that N_CH itself is representable for the range check.
    localparam logic [CH_W:0]    N_CH_L    = (CH_W + 1)'(N_CH);
    localparam logic [DIV_W-1:0] DEF_DIV_L = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE_L     = {{(DIV_W - 1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] ZERO_L    = {DIV_W{1'b0}};

    // Terminal count for a divisor; a programmed zero behaves like a divide-by-one.
    function automatic logic [DIV_W-1:0] last_count(input logic [DIV_W-1:0] div);
        logic [DIV_W-1:0] last;
        if (div == ZERO_L) begin
            last = ZERO_L;
        end else begin
            last = div - ONE_L;
        end
        return last;
    endfunction

    logic [N_CH-1:0][DIV_W-1:0] div_r;
    logic [N_CH-1:0][DIV_W-1:0] cnt_r;
    logic [N_CH-1:0]            tick_r;
    logic [N_CH-1:0]            clock_out_r;
    logic                       cfg_ack_r;
    logic                       cfg_err_r;

    logic                       cfg_ok_s;
    logic                       cfg_bad_s;
    logic [N_CH-1:0]            wr_sel_s;

    // Classify a config strobe as accepted (valid channel) or rejected.
    always_comb begin
        cfg_ok_s  = 1'b0;
        cfg_bad_s = 1'b0;
        if (bus.cfg_wr) begin
            if ({1'b0, bus.cfg_ch} < N_CH_L) begin
                cfg_ok_s = 1'b1;
            end else begin
                cfg_bad_s = 1'b1;
            end
        end else begin
            cfg_ok_s  = 1'b0;
            cfg_bad_s = 1'b0;
        end
    end

    // Decode the accepted write into a one-hot per-channel select.
    always_comb begin
        wr_sel_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ok_s && (bus.cfg_ch == CH_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Per-channel divider state, config handshake and registered outputs.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            cfg_ack_r   <= 1'b0;
            cfg_err_r   <= 1'b0;
            tick_r      <= {N_CH{1'b0}};
            clock_out_r <= {N_CH{1'b0}};
            for (int i = 0; i < N_CH; i++) begin
                div_r[i] <= DEF_DIV_L;
                cnt_r[i] <= ZERO_L;
            end
        end else begin
            cfg_ack_r <= cfg_ok_s;
            cfg_err_r <= cfg_bad_s;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_sel_s[i]) begin
                    div_r[i] <= bus.cfg_div;
                end else begin
                    div_r[i] <= div_r[i];
                end

                // A divisor write or a resync restarts the period and drops any
                // terminal count that was about to fire; only resync clears the wave.
                if (bus.sync || wr_sel_s[i]) begin
                    cnt_r[i]  <= ZERO_L;
                    tick_r[i] <= 1'b0;
                    if (bus.sync) begin
                        clock_out_r[i] <= 1'b0;
                    end else begin
                        clock_out_r[i] <= clock_out_r[i];
                    end
                end else if (bus.en[i]) begin
                    if (cnt_r[i] >= last_count(div_r[i])) begin
                        cnt_r[i]       <= ZERO_L;
                        tick_r[i]      <= 1'b1;
                        clock_out_r[i] <= ~clock_out_r[i];
                    end else begin
                        cnt_r[i]  <= cnt_r[i] + ONE_L;
                        tick_r[i] <= 1'b0;
                    end
                end else begin
                    // Paused channel keeps its phase so re-enable loses nothing.
                    tick_r[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.tick      = tick_r;
    assign bus.clock_out = clock_out_r;
    assign bus.cfg_ack   = cfg_ack_r;
    assign bus.cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen: expected tick/ack/err vectors are queued as each
// step is driven and popped one per clock when the DUT output is sampled.
module tb_multi_tick_gen;

    localparam int N_CH        = 4;
    localparam int DIV_W       = 26;
    localparam int CH_W        = 3;
    localparam int DEFAULT_DIV = 25000000;

    logic clock_50 = 1'b0;
    logic reset;

    multi_tick_gen_if #(.N_CH(N_CH), .DIV_W(DIV_W), .CH_W(CH_W)) bus ();

    multi_tick_gen #(
        .N_CH(N_CH), .DIV_W(DIV_W), .CH_W(CH_W), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clock_50(clock_50),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clock_50 = ~clock_50;

    typedef struct {
        string      tag;
        logic [3:0] tick;
        logic       ack;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic push(input string tag, input logic [3:0] t, input logic a, input logic e);
        exp_t x;
        x.tag  = tag;
        x.tick = t;
        x.ack  = a;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Advance one clock, sample 1 time unit later and retire one queued expectation.
    task automatic cyc();
        exp_t x;
        @(posedge clock_50);
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            tests_run++;
            assert ({bus.tick, bus.cfg_ack, bus.cfg_err} === {x.tick, x.ack, x.err})
            else begin
                tests_failed++;
                $error("FAIL %s: tick/ack/err observed %b/%b/%b expected %b/%b/%b",
                       x.tag, bus.tick, bus.cfg_ack, bus.cfg_err, x.tick, x.ack, x.err);
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wr_cfg(input int ch, input int div);
        bus.cfg_wr  = 1'b1;
        bus.cfg_ch  = CH_W'(ch);
        bus.cfg_div = DIV_W'(div);
    endtask

    task automatic wr_idle();
        bus.cfg_wr  = 1'b0;
        bus.cfg_ch  = {CH_W{1'b0}};
        bus.cfg_div = {DIV_W{1'b0}};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] t;

        reset    = 1'b1;
        bus.en   = 4'b0000;
        bus.sync = 1'b0;
        wr_idle();
        repeat (3) @(posedge clock_50);
        #1;
        check("rst_tick", bus.tick, 4'b0000);
        check("rst_clock_out", bus.clock_out, 4'b0000);
        check("rst_ack_err", {2'b00, bus.cfg_ack, bus.cfg_err}, 4'b0000);
        reset  = 1'b0;
        bus.en = 4'b1111;

        // ch0 divisor 5: tick every 5 cycles after the ack edge, clock_out period 10.
        wr_cfg(0, 5);
        push("cfg0_d5_ack", 4'b0000, 1'b1, 1'b0);
        cyc();
        wr_idle();
        for (int j = 1; j <= 10; j++) begin
            push("ch0_d5", (j % 5 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
        end
        for (int j = 1; j <= 10; j++) begin
            cyc();
            if (j == 5) check("ch0_clk_hi", {3'b000, bus.clock_out[0]}, 4'b0001);
            if (j == 9) check("ch0_clk_hold", {3'b000, bus.clock_out[0]}, 4'b0001);
            if (j == 10) check("ch0_clk_lo", {3'b000, bus.clock_out[0]}, 4'b0000);
        end

        // ch1 div=0 and ch2 div=1 written back to back: both tick every cycle.
        wr_cfg(1, 0);
        push("cfg1_d0_ack", 4'b0000, 1'b1, 1'b0);
        cyc();
        wr_cfg(2, 1);
        push("cfg2_d1_ack", 4'b0010, 1'b1, 1'b0);
        cyc();
        wr_idle();
        for (int j = 13; j <= 18; j++) begin
            push("d0_d1_every", (j == 15) ? 4'b0111 : 4'b0110, 1'b0, 1'b0);
        end
        for (int j = 13; j <= 18; j++) begin
            cyc();
            if (j == 15) check("mixed_clock_out", bus.clock_out, 4'b0101);
        end

        // Pause ch0 at count 3 for 7 cycles, then resume: tick 2 cycles later.
        bus.en = 4'b1110;
        for (int j = 0; j < 7; j++) push("ch0_paused", 4'b0110, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) cyc();
        check("ch0_clk_held", {3'b000, bus.clock_out[0]}, 4'b0001);
        bus.en = 4'b1111;
        push("ch0_resume1", 4'b0110, 1'b0, 1'b0);
        push("ch0_resume2", 4'b0111, 1'b0, 1'b0);
        cyc();
        cyc();
        check("ch0_clk_resume", {3'b000, bus.clock_out[0]}, 4'b0000);

        // Rewrite ch0 to 8 while its count sits at 4: that tick is suppressed.
        for (int j = 0; j < 4; j++) push("ch0_run", 4'b0110, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) cyc();
        wr_cfg(0, 8);
        push("cfg0_d8_suppress", 4'b0110, 1'b1, 1'b0);
        cyc();
        wr_idle();
        for (int j = 1; j <= 8; j++) push("ch0_d8", (j == 8) ? 4'b0111 : 4'b0110, 1'b0, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            cyc();
            if (j == 7) check("ch0_d8_clk_lo", {3'b000, bus.clock_out[0]}, 4'b0000);
            if (j == 8) check("ch0_d8_clk_hi", {3'b000, bus.clock_out[0]}, 4'b0001);
        end

        // Out-of-range channel: error pulse, no ack, ch0 period of 8 unchanged.
        wr_cfg(5, 2);
        push("cfg_bad_ch", 4'b0110, 1'b0, 1'b1);
        cyc();
        wr_idle();
        for (int j = 2; j <= 8; j++) push("ch0_d8_kept", (j == 8) ? 4'b0111 : 4'b0110, 1'b0, 1'b0);
        for (int j = 2; j <= 8; j++) cyc();

        // Mixed divisors 3/5/7, the last one written in the same cycle as SYNC.
        wr_cfg(0, 3);
        push("cfg0_d3_ack", 4'b0110, 1'b1, 1'b0);
        cyc();
        wr_cfg(1, 5);
        push("cfg1_d5_ack", 4'b0100, 1'b1, 1'b0);
        cyc();
        wr_idle();
        repeat (3) cyc();
        bus.sync = 1'b1;
        wr_cfg(2, 7);
        push("sync_cfg_ack", 4'b0000, 1'b1, 1'b0);
        cyc();
        bus.sync = 1'b0;
        wr_idle();
        check("sync_clock_out", bus.clock_out, 4'b0000);
        for (int j = 1; j <= 21; j++) begin
            t = 4'b0000;
            if (j % 3 == 0) t[0] = 1'b1;
            if (j % 5 == 0) t[1] = 1'b1;
            if (j % 7 == 0) t[2] = 1'b1;
            push("sync_aligned", t, 1'b0, 1'b0);
        end
        for (int j = 1; j <= 21; j++) begin
            cyc();
            if (j == 7) check("sync_clock_out_7", bus.clock_out, 4'b0110);
        end

        // Reset between edges clears outputs without waiting for the clock.
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_tick", bus.tick, 4'b0000);
        check("async_rst_clock_out", bus.clock_out, 4'b0000);
        reset = 1'b0;
        // Programmed divisors are gone: default divisor keeps every channel silent.
        for (int j = 0; j < 10; j++) push("post_rst_default", 4'b0000, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) cyc();
        check("post_rst_clock_out", bus.clock_out, 4'b0000);

        tests_run++;
        assert (sb.size() == 0)
        else begin
            tests_failed++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
